// File: rtl/pc_pkg.sv
// Shared definitions for the PATP program counter: operation encoding and widths.
package pc_pkg;

    localparam int PC_OP_W = 3;

    // Operation codes supplied by the decoder; codes 6 and 7 are treated as HOLD.
    typedef enum logic [PC_OP_W-1:0] {
        NEXT   = 3'd0,
        JUMP   = 3'd1,
        BRANCH = 3'd2,
        CALL   = 3'd3,
        RET    = 3'd4,
        HOLD   = 3'd5
    } pc_op_t;

endpackage

// File: rtl/pc_unit_if.sv
// Decoder <-> program-counter bus. The master (decoder side) drives the
// operation request; the slave (pc_unit) returns the fetch address and status.
interface pc_unit_if
    import pc_pkg::*;
#(
    parameter int ADDR_W = 5
);
    logic               step;
    logic [PC_OP_W-1:0] op;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  offset;
    logic               cond;
    logic               err_clr;
    logic [ADDR_W-1:0]  pc;
    logic               stack_full;
    logic               stack_empty;
    logic               ovf;
    logic               unf;

    modport master (
        output step, op, target, offset, cond, err_clr,
        input  pc, stack_full, stack_empty, ovf, unf
    );

    modport slave (
        input  step, op, target, offset, cond, err_clr,
        output pc, stack_full, stack_empty, ovf, unf
    );
endinterface

// File: rtl/pc_ret_stack.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry (the slot just above the top pointer) and keeps the count saturated;
// a pop while empty changes nothing. ovf/unf are single-cycle pulses.
module pc_ret_stack #(
    parameter int ADDR_W      = 5,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic              full,
    output logic              empty,
    output logic              ovf_pulse,
    output logic              unf_pulse
);
    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] mem_r [STACK_DEPTH];
    logic [PTR_W-1:0]  top_r;
    logic [CNT_W-1:0]  count_r;
    logic [PTR_W-1:0]  top_inc_s;
    logic              do_pop_s;

    assign top_inc_s = top_r + PTR_W'(1);
    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == CNT_W'(0));
    assign top_data  = mem_r[top_r];
    assign do_pop_s  = pop & ~push & ~empty;
    assign ovf_pulse = push & full;
    assign unf_pulse = pop & ~push & empty;

    // Entry storage; contents after reset are don't-care so no reset here.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[top_inc_s] <= push_data;
        end
    end

    // Top pointer and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top_r   <= PTR_W'(0);
            count_r <= CNT_W'(0);
        end else if (push) begin
            top_r   <= top_inc_s;
            count_r <= full ? count_r : count_r + CNT_W'(1);
        end else if (do_pop_s) begin
            top_r   <= top_r - PTR_W'(1);
            count_r <= count_r - CNT_W'(1);
        end else begin
            top_r   <= top_r;
            count_r <= count_r;
        end
    end
endmodule

// File: rtl/pc_unit.sv
// Parametrised program counter: increment, jump, PC-relative branch and,
// when PC_STACK_EN is defined, call/return through a return-address stack
// with sticky overflow/underflow flags. Without PC_STACK_EN, CALL acts as
// JUMP, RET acts as NEXT and the stack status outputs are constants.
module pc_unit
    import pc_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0
) (
    input  logic        clk,
    input  logic        rst,
    pc_unit_if.slave    bus
);
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_next_s;
    logic [ADDR_W-1:0] pc_inc_s;

    assign pc_inc_s = pc_r + ADDR_W'(1);
    assign bus.pc   = pc_r;

`ifdef PC_STACK_EN
    logic              push_s;
    logic              pop_s;
    logic [ADDR_W-1:0] top_data_s;
    logic              full_s;
    logic              empty_s;
    logic              ovf_pulse_s;
    logic              unf_pulse_s;
    logic              ovf_r;
    logic              unf_r;

    pc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_inc_s),
        .top_data  (top_data_s),
        .full      (full_s),
        .empty     (empty_s),
        .ovf_pulse (ovf_pulse_s),
        .unf_pulse (unf_pulse_s)
    );

    assign bus.stack_full  = full_s;
    assign bus.stack_empty = empty_s;
    assign bus.ovf         = ovf_r;
    assign bus.unf         = unf_r;
`else
    logic unused_err_clr_s;

    assign unused_err_clr_s = bus.err_clr;
    assign bus.stack_full   = 1'b0;
    assign bus.stack_empty  = 1'b1;
    assign bus.ovf          = 1'b0;
    assign bus.unf          = 1'b0;
`endif

    // Next-address mux and stack push/pop requests for the current operation.
    always_comb begin
        pc_next_s = pc_r;
`ifdef PC_STACK_EN
        push_s    = 1'b0;
        pop_s     = 1'b0;
`endif
        if (bus.step) begin
            case (bus.op)
                NEXT:   pc_next_s = pc_inc_s;
                JUMP:   pc_next_s = bus.target;
                BRANCH: begin
                    if (bus.cond) begin
                        pc_next_s = pc_r + bus.offset;
                    end else begin
                        pc_next_s = pc_inc_s;
                    end
                end
                CALL: begin
                    pc_next_s = bus.target;
`ifdef PC_STACK_EN
                    push_s    = 1'b1;
`endif
                end
                RET: begin
`ifdef PC_STACK_EN
                    pop_s = 1'b1;
                    if (empty_s) begin
                        pc_next_s = pc_inc_s;
                    end else begin
                        pc_next_s = top_data_s;
                    end
`else
                    pc_next_s = pc_inc_s;
`endif
                end
                default: pc_next_s = pc_r;
            endcase
        end else begin
            pc_next_s = pc_r;
        end
    end

    // Fetch-address register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r <= ADDR_W'(RESET_ADDR);
        end else begin
            pc_r <= pc_next_s;
        end
    end

`ifdef PC_STACK_EN
    // Sticky overflow flag; a new overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_r <= 1'b0;
        end else if (ovf_pulse_s) begin
            ovf_r <= 1'b1;
        end else if (bus.err_clr) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Sticky underflow flag; a new underflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            unf_r <= 1'b0;
        end else if (unf_pulse_s) begin
            unf_r <= 1'b1;
        end else if (bus.err_clr) begin
            unf_r <= 1'b0;
        end else begin
            unf_r <= unf_r;
        end
    end
`endif
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit (ADDR_W=5, STACK_DEPTH=4, RESET_ADDR=0).
// Works with or without PC_STACK_EN; the reference model follows the build.
module tb_pc_unit;
    import pc_pkg::*;

    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int MOD   = 32;

    typedef struct {
        int pc;
        bit full;
        bit empty;
        bit ovf;
        bit unf;
    } exp_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    // Reference model state
    int   m_pc;
    int   m_stk[$];
    bit   m_ovf;
    bit   m_unf;

    pc_unit_if #(.ADDR_W(AW)) bus ();

    pc_unit #(
        .ADDR_W      (AW),
        .STACK_DEPTH (DEPTH),
        .RESET_ADDR  (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.pc    = m_pc;
        e.full  = (m_stk.size() == DEPTH);
        e.empty = (m_stk.size() == 0);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        return e;
    endfunction

    // Issue one operation on a falling edge, advance the model, queue the
    // expected post-edge state, then quiesce the strobes after the edge.
    task automatic do_op(input bit st, input int op, input int tgt,
                         input int off, input bit cnd, input bit clr);
        bit new_ovf = 1'b0;
        bit new_unf = 1'b0;
        @(negedge clk);
        bus.step    = st;
        bus.op      = 3'(op);
        bus.target  = 5'(tgt);
        bus.offset  = 5'(off);
        bus.cond    = cnd;
        bus.err_clr = clr;
        if (st) begin
            case (op)
                0: m_pc = (m_pc + 1) % MOD;
                1: m_pc = tgt % MOD;
                2: m_pc = cnd ? (m_pc + off) % MOD : (m_pc + 1) % MOD;
                3: begin
`ifdef PC_STACK_EN
                    if (m_stk.size() == DEPTH) begin
                        void'(m_stk.pop_front());
                        new_ovf = 1'b1;
                    end
                    m_stk.push_back((m_pc + 1) % MOD);
`endif
                    m_pc = tgt % MOD;
                end
                4: begin
`ifdef PC_STACK_EN
                    if (m_stk.size() == 0) begin
                        m_pc = (m_pc + 1) % MOD;
                        new_unf = 1'b1;
                    end else begin
                        m_pc = m_stk.pop_back();
                    end
`else
                    m_pc = (m_pc + 1) % MOD;
`endif
                end
                default: ;
            endcase
        end
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (new_ovf) m_ovf = 1'b1;
        if (new_unf) m_unf = 1'b1;
        exp_q.push_back(model_snapshot());
        @(posedge clk);
        #2;
        bus.step    = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic model_reset();
        m_pc  = 0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"},    16'(bus.pc), 16'd0);
        chk({tag, "_empty"}, 16'(bus.stack_empty), 16'd1);
        chk({tag, "_full"},  16'(bus.stack_full), 16'd0);
        chk({tag, "_ovf"},   16'(bus.ovf), 16'd0);
        chk({tag, "_unf"},   16'(bus.unf), 16'd0);
    endtask

    // Monitor: after every rising edge, compare DUT outputs with the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_pc",    16'(bus.pc),          16'(e.pc));
                chk("sb_full",  16'(bus.stack_full),  16'(e.full));
                chk("sb_empty", 16'(bus.stack_empty), 16'(e.empty));
                chk("sb_ovf",   16'(bus.ovf),         16'(e.ovf));
                chk("sb_unf",   16'(bus.unf),         16'(e.unf));
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        rst         = 1'b0;
        bus.step    = 1'b0;
        bus.op      = 3'd0;
        bus.target  = 5'd0;
        bus.offset  = 5'd0;
        bus.cond    = 1'b0;
        bus.err_clr = 1'b0;
        model_reset();
        #3;
        chk_reset_state("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Increment and wrap
        for (int i = 0; i < 32; i++) begin
            do_op(1'b1, 0, 0, 0, 1'b0, 1'b0);
            if (i == 30) chk("inc_31", 16'(bus.pc), 16'd31);
        end
        chk("inc_wrap0", 16'(bus.pc), 16'd0);
        do_op(1'b1, 0, 0, 0, 1'b0, 1'b0);
        chk("inc_1", 16'(bus.pc), 16'd1);

        // Hold versus step
        do_op(1'b0, 1, 20, 0, 1'b0, 1'b0);
        chk("jump_nostep", 16'(bus.pc), 16'd1);
        do_op(1'b1, 1, 20, 0, 1'b0, 1'b0);
        chk("jump_step", 16'(bus.pc), 16'd20);
        do_op(1'b1, 5, 3, 3, 1'b1, 1'b0);
        chk("hold", 16'(bus.pc), 16'd20);

        // Relative branch
        do_op(1'b1, 1, 4, 0, 1'b0, 1'b0);
        do_op(1'b1, 2, 0, 30, 1'b1, 1'b0);
        chk("br_back", 16'(bus.pc), 16'd2);
        do_op(1'b1, 1, 4, 0, 1'b0, 1'b0);
        do_op(1'b1, 2, 0, 30, 1'b0, 1'b0);
        chk("br_not_taken", 16'(bus.pc), 16'd5);
        do_op(1'b1, 1, 30, 0, 1'b0, 1'b0);
        do_op(1'b1, 2, 0, 3, 1'b1, 1'b0);
        chk("br_wrap", 16'(bus.pc), 16'd1);

        // Call nesting and overflow
        do_op(1'b1, 1, 2, 0, 1'b0, 1'b0);
        do_op(1'b1, 3, 10, 0, 1'b0, 1'b0);
        do_op(1'b1, 3, 20, 0, 1'b0, 1'b0);
        do_op(1'b1, 3, 25, 0, 1'b0, 1'b0);
        do_op(1'b1, 3, 28, 0, 1'b0, 1'b0);
`ifdef PC_STACK_EN
        chk("call_full", 16'(bus.stack_full), 16'd1);
`endif
        do_op(1'b1, 3, 6, 0, 1'b0, 1'b0);
        chk("call_ovf_pc", 16'(bus.pc), 16'd6);
`ifdef PC_STACK_EN
        chk("call_ovf_flag", 16'(bus.ovf), 16'd1);
        do_op(1'b1, 4, 0, 0, 1'b0, 1'b0);
        chk("ret1", 16'(bus.pc), 16'd29);
        do_op(1'b1, 4, 0, 0, 1'b0, 1'b0);
        chk("ret2", 16'(bus.pc), 16'd26);
        do_op(1'b1, 4, 0, 0, 1'b0, 1'b0);
        chk("ret3", 16'(bus.pc), 16'd21);
        do_op(1'b1, 4, 0, 0, 1'b0, 1'b0);
        chk("ret4", 16'(bus.pc), 16'd11);
        chk("ret_empty", 16'(bus.stack_empty), 16'd1);
`else
        for (int i = 0; i < 4; i++) do_op(1'b1, 4, 0, 0, 1'b0, 1'b0);
        chk("ret_as_next", 16'(bus.pc), 16'd10);
`endif

        // Underflow and flag clear
        do_op(1'b0, 0, 0, 0, 1'b0, 1'b1);
        do_op(1'b1, 1, 7, 0, 1'b0, 1'b0);
        do_op(1'b1, 4, 0, 0, 1'b0, 1'b0);
        chk("unf_pc", 16'(bus.pc), 16'd8);
`ifdef PC_STACK_EN
        chk("unf_set", 16'(bus.unf), 16'd1);
        do_op(1'b0, 0, 0, 0, 1'b0, 1'b1);
        chk("unf_clr", 16'(bus.unf), 16'd0);
        do_op(1'b1, 4, 0, 0, 1'b0, 1'b1);
        chk("unf_wins", 16'(bus.unf), 16'd1);
`endif

        // Call/return back-to-back, then async reset after two calls
        do_op(1'b0, 0, 0, 0, 1'b0, 1'b1);
        do_op(1'b1, 3, 9, 0, 1'b0, 1'b0);
        chk("call9", 16'(bus.pc), 16'd9);
        do_op(1'b1, 4, 0, 0, 1'b0, 1'b0);
        chk("ret10", 16'(bus.pc), 16'd10);
        do_op(1'b1, 3, 12, 0, 1'b0, 1'b0);
        do_op(1'b1, 3, 13, 0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk_reset_state("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Randomised operations against the reference model
        for (int i = 0; i < 400; i++) begin
            do_op($urandom_range(0, 7) != 0, int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program counter for the PATP core, replacing the fixed 5-bit load-only counter. It holds the fetch address and, on each execute strobe, either auto-increments, takes an absolute jump, takes a conditional PC-relative branch, or performs call/return through an internal return-address stack. It sits between the decoder, which supplies `op`, `target`, `offset` and `cond`, and instruction memory, which consumes `pc`.

## Interface
- `ADDR_W`, 5, address width in bits; legal range 2–16.
- `STACK_DEPTH`, 4, number of return-stack entries; must be a power of two, ≥2.
- `RESET_ADDR`, 0, value loaded into `pc` on reset.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `step`  in  1  advance strobe; when low, all state holds.
- `op`  in  3  operation: NEXT=0, JUMP=1, BRANCH=2, CALL=3, RET=4, HOLD=5; 6 and 7 behave as HOLD.
- `target`  in  ADDR_W  absolute address for JUMP and CALL.
- `offset`  in  ADDR_W  two's-complement displacement for BRANCH.
- `cond`  in  1  BRANCH is taken only when high.
- `err_clr`  in  1  clears the sticky error flags.
- `pc`  out  ADDR_W  current address, registered; reset value `RESET_ADDR`.
- `stack_full`  out  1  stack holds `STACK_DEPTH` entries; reset value 0.
- `stack_empty`  out  1  stack holds 0 entries; reset value 1.
- `ovf`  out  1  sticky flag, set on CALL while full; reset value 0.
- `unf`  out  1  sticky flag, set on RET while empty; reset value 0.

## Operation
- `step`=0: `pc`, the stack and its count hold. Flags change only through `err_clr`.
- With `step`=1, the operation executes on the edge:
  - NEXT: `pc <= pc+1`.
  - JUMP: `pc <= target`.
  - BRANCH: if `cond`, `pc <= pc+offset`; otherwise `pc <= pc+1`. The offset is relative to the current `pc`, not `pc+1`.
  - CALL: push `pc+1`, then `pc <= target`.
  - RET: pop the top entry into `pc`.
  - HOLD: no change.
- Arithmetic is modulo 2^ADDR_W; wrap-around is silent. 2^ADDR_W−1 + 1 gives 0. Offset sign bit is bit ADDR_W−1.
- The stack is a circular buffer with a top pointer and a count from 0 to STACK_DEPTH.
- CALL while full:
  - The jump is still taken.
  - The push overwrites the oldest entry.
  - Count stays at STACK_DEPTH.
  - `ovf` is set.
- RET while empty: `pc <= pc+1`, count stays 0, `unf` is set.
- Sticky flags:
  - `err_clr` clears `ovf` and `unf` regardless of `step`.
  - If `err_clr` arrives in the same cycle as a new overflow or underflow, the new error wins and the flag is set.
- Reset while active, at any point, including mid-call sequences:
  - `pc` returns to RESET_ADDR.
  - Count goes to 0 and both flags clear.
  - Stack contents are don't-care.

## Timing
- Single-cycle latency: `pc` and the flags reflect an operation immediately after the edge on which `step`=1.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `stack_full` and `stack_empty` are decoded from the registered count.
- Back-to-back operations are legal every cycle, e.g. CALL then RET on consecutive cycles returns to the caller's `pc+1`.
- Reset is asserted asynchronously. Deassertion is expected synchronous to `clk` and is handled by the upstream reset synchroniser.

## Configuration
- `PC_STACK_EN` defined: the return stack, call/return behaviour and the `ovf`/`unf` flags are built as above.
- Undefined:
  - No stack storage is instantiated.
  - CALL behaves as JUMP and RET behaves as NEXT.
  - `stack_full`=0, `stack_empty`=1, `ovf`=0 and `unf`=0 are tied constants.

## Structure
- Package `pc_pkg` holds:
  - the `pc_op_t` enum (NEXT, JUMP, BRANCH, CALL, RET, HOLD);
  - the op width constant `PC_OP_W=3`.
- Sub-module `pc_ret_stack`, parametrised by ADDR_W and STACK_DEPTH:
  - inputs: push, pop, push data;
  - outputs: top data, full, empty, ovf pulse, unf pulse.
- `pc_unit` owns the address register, next-address mux and sticky flags. It instantiates `pc_ret_stack` only under `PC_STACK_EN`.

## Test plan
- Reset and increment: ADDR_W=5, `rst` low then high, NEXT ×33 → `pc` reaches 31 then wraps to 0 then 1; `stack_empty`=1 throughout.
- Hold versus step:
  - JUMP `target`=0x14 with `step`=0 → `pc` unchanged.
  - Same with `step`=1 → `pc`=0x14.
  - HOLD → `pc` stays 0x14.
- Relative branch at `pc`=4:
  - `offset`=0x1E (−2), `cond`=1 → `pc`=2.
  - `cond`=0 → `pc`=5.
  - At `pc`=30, `offset`=3, `cond`=1 → `pc`=1.
- Call nesting, STACK_DEPTH=4:
  - From `pc`=2, CALLs to 10, 20, 25, 28 → `stack_full`=1.
  - A fifth CALL to 6 → `ovf`=1, `pc`=6.
  - RET ×4 → `pc`=29, 26, 21, 11; then `stack_empty`=1.
- Underflow and flag clear:
  - RET while empty at `pc`=7 → `pc`=8, `unf`=1.
  - `err_clr` → `unf`=0.
  - `err_clr` together with RET while empty → `unf`=1.
- Async reset mid-sequence: assert `rst` between clock edges after two CALLs → `pc`=RESET_ADDR, `stack_empty`=1 and flags 0, all before the next edge. Repeat with `PC_STACK_EN` undefined: CALL to 9 → `pc`=9; RET → `pc`=10.
